// File: rtl/starfish_mem_pkg.sv
// Shared types for the Starfish memory arbiter: response owner tags and the muxed memory request.
// Struct fields are sized for the widest supported configuration (32-bit address and data).
package starfish_mem_pkg;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int MEM_ADDR_W      = 32;
  localparam int MEM_DATA_W      = 32;
  localparam int MEM_BE_W        = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/starfish_resp_tracker.sv
// Owner-tag delay line: the tag pushed with a grant appears at tail_o exactly DEPTH cycles later.
// Accepts a tag every cycle, never stalls; synchronous reset flushes every stage to OWN_NONE.
module starfish_resp_tracker
  import starfish_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tag_i,
  output logic [1:0] tail_o
);

  owner_e pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= OWN_NONE;
    end else begin
      pipe_q[0] <= owner_e'(tag_i);
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/starfish_mem_arbiter.sv
// Shares one pipelined memory port between fetch (IF) and load/store (LS); grants are same-cycle
// combinational, responses return MEM_LATENCY cycles after grant, LS wins unless IF is starved.
module starfish_mem_arbiter
  import starfish_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("MEM_LATENCY out of range");
  end

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_force;
  mem_req_t         req_sel;
  logic [1:0]       push_tag;
  logic [1:0]       tail_tag;

  assign if_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Nothing is granted while in reset so no transaction can straddle it.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req && ls_req) begin
        if_gnt = if_force;
        ls_gnt = !if_force;
      end else begin
        if_gnt = if_req;
        ls_gnt = ls_req;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && !if_force) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    req_sel = '0;
    if (if_gnt) begin
      req_sel.be   = '1;
      req_sel.addr = MEM_ADDR_W'(if_addr);
    end else if (ls_gnt) begin
      req_sel.we    = ls_we;
      req_sel.be    = MEM_BE_W'(ls_be);
      req_sel.addr  = MEM_ADDR_W'(ls_addr);
      req_sel.wdata = MEM_DATA_W'(ls_wdata);
    end
  end

  assign mem_en    = if_gnt | ls_gnt;
  assign mem_we    = req_sel.we;
  assign mem_be    = req_sel.be[BE_W-1:0];
  assign mem_addr  = req_sel.addr[ADDR_W-1:0];
  assign mem_wdata = req_sel.wdata[DATA_W-1:0];

  assign push_tag = if_gnt ? OWN_IF : (ls_gnt ? OWN_LS : OWN_NONE);

  starfish_resp_tracker #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_tracker (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (push_tag),
    .tail_o (tail_tag)
  );

  // Responses due in the reset cycle belong to pre-reset grants and are dropped.
  assign if_rvalid = !rst && (tail_tag == OWN_IF);
  assign ls_rvalid = !rst && (tail_tag == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule
